dmem_access_ctrl: RTL and testbench

Arbitrating access controller in front of the single-port, word-wide, synchronous-read data RAM. It shares the RAM between two requesters: port 0 is the CPU load/store path, port 1 is the boot-loader/debug port. It formats loads (lb/lh/lw/lbu/lhu) and turns byte and halfword stores into read-modify-write sequences, because the RAM only supports whole-word writes. One operation is in flight at a time, and the two ports are arbitrated round-robin.

---
 rtl/dmem_access_ctrl_if.sv | 35 +++
 rtl/dmem_access_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
//   Requester-side bundle of dmem_access_ctrl. One instance per requester port.
//
//   req      requester -> ctrl  request, fields held stable until gnt
//   we       requester -> ctrl  1 = store, 0 = load
//   op_type  requester -> ctrl  000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr     requester -> ctrl  byte address
//   wdata    requester -> ctrl  right-aligned store data
//   gnt      ctrl -> requester  combinational accept pulse
//   done     ctrl -> requester  registered completion pulse
//   err      ctrl -> requester  valid with done; misaligned / illegal type
//   rdata    ctrl -> requester  formatted load data, held until next done
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  op_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, op_type, addr, wdata,
        input  gnt, done, err, rdata
    );

    modport slave (
        input  req, we, op_type, addr, wdata,
        output gnt, done, err, rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//   Round-robin arbiter and access sequencer in front of a single-port,
//   word-wide, synchronous-read data RAM. Formats sub-word loads and turns
//   byte/halfword stores into read-modify-write sequences.
//
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   p0, p1    requester ports (p0 = CPU load/store, p1 = boot/debug)
//   mem_we    RAM word write enable
//   mem_addr  RAM word address (byte addr[MEM_AW+1:2])
//   mem_din   RAM write data
//   mem_dout  RAM read data, valid the cycle after the address
//   busy      an operation is in flight
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int MEM_AW = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_access_ctrl_if.slave   p0,
    dmem_access_ctrl_if.slave   p1,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [31:0]         mem_din,
    input  logic [31:0]         mem_dout,
    output logic                busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_WRBACK  = 2'd3;

    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    logic [1:0]        state;
    logic              last_gnt;     // 1 = port 1 was granted last
    logic              cmd_we;
    logic [2:0]        cmd_type;
    logic [MEM_AW+1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              cmd_port;
    logic [31:0]       wr_word;      // word presented on mem_din

    // Illegal type or misalignment for the given direction.
    function automatic logic cmd_illegal(input logic we, input logic [2:0] t,
                                         input logic [1:0] a);
        logic bad;
        case (t)
            T_B:     bad = 1'b0;
            T_H:     bad = a[0];
            T_W:     bad = (a != 2'b00);
            T_BU:    bad = we;
            T_HU:    bad = we | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration: on a tie, the port not granted last wins.
    // -------------------------------------------------------------------------
    logic              idle;
    logic              gnt0, gnt1, any_gnt;
    logic              s_we, s_err;
    logic [2:0]        s_type;
    logic [MEM_AW+1:0] s_addr;
    logic [31:0]       s_wdata;

    assign idle    = (state == S_IDLE);
    assign gnt0    = idle & p0.req & (~p1.req | last_gnt);
    assign gnt1    = idle & p1.req & (~p0.req | ~last_gnt);
    assign any_gnt = gnt0 | gnt1;
    assign p0.gnt  = gnt0;
    assign p1.gnt  = gnt1;

    assign s_we    = gnt1 ? p1.we      : p0.we;
    assign s_type  = gnt1 ? p1.op_type : p0.op_type;
    assign s_addr  = gnt1 ? p1.addr[MEM_AW+1:0] : p0.addr[MEM_AW+1:0];
    assign s_wdata = gnt1 ? p1.wdata   : p0.wdata;
    assign s_err   = cmd_illegal(s_we, s_type, s_addr[1:0]);

    // -------------------------------------------------------------------------
    // Datapath: load formatting and sub-word merge, both from mem_dout.
    // -------------------------------------------------------------------------
    logic [31:0] byte_sh, half_sh, load_fmt, merged;

    assign byte_sh = mem_dout >> {cmd_addr[1:0], 3'b000};
    assign half_sh = mem_dout >> {cmd_addr[1], 4'b0000};

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        load_fmt = mem_dout;
        case (cmd_type)
            T_B:     load_fmt = {{24{byte_sh[7]}}, byte_sh[7:0]};
            T_BU:    load_fmt = {24'h0, byte_sh[7:0]};
            T_H:     load_fmt = {{16{half_sh[15]}}, half_sh[15:0]};
            T_HU:    load_fmt = {16'h0, half_sh[15:0]};
            default: load_fmt = mem_dout;
        endcase
    end

    always_comb begin
        merged = mem_dout;
        if (cmd_type == T_H)
            merged[{cmd_addr[1], 4'b0000} +: 16] = cmd_wdata[15:0];
        else
            merged[{cmd_addr[1:0], 3'b000} +: 8] = cmd_wdata[7:0];
    end

    // Final cycle of a successful operation; done follows one cycle later.
    logic word_store, finish;
    assign word_store = cmd_we & (cmd_type == T_W);
    assign finish = ((state == S_ACCESS)  &  word_store) |
                    ((state == S_CAPTURE) & ~cmd_we)     |
                     (state == S_WRBACK);

    // -------------------------------------------------------------------------
    // Sequencer. Errored grants never load the command registers, so mem_addr
    // and mem_din keep showing the last real access while idle.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            last_gnt  <= 1'b1;
            cmd_we    <= 1'b0;
            cmd_type  <= T_B;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_port  <= 1'b0;
            wr_word   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_gnt) begin
                        last_gnt <= gnt1;
                        if (!s_err) begin
                            state     <= S_ACCESS;
                            cmd_we    <= s_we;
                            cmd_type  <= s_type;
                            cmd_addr  <= s_addr;
                            cmd_wdata <= s_wdata;
                            cmd_port  <= gnt1;
                            if (s_we && (s_type == T_W))
                                wr_word <= s_wdata;
                        end
                    end
                end
                S_ACCESS:  state <= word_store ? S_IDLE : S_CAPTURE;
                S_CAPTURE: begin
                    if (cmd_we) begin
                        wr_word <= merged;
                        state   <= S_WRBACK;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-port completion: done/err pulses and held load data.
    // -------------------------------------------------------------------------
    logic        done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        load_cap;

    assign load_cap = (state == S_CAPTURE) & ~cmd_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done0  <= 1'b0;
            done1  <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            done0 <= (finish & ~cmd_port) | (gnt0 & s_err);
            done1 <= (finish &  cmd_port) | (gnt1 & s_err);
            err0  <= gnt0 & s_err;
            err1  <= gnt1 & s_err;
            if (gnt0 && s_err)             rdata0 <= '0;
            else if (load_cap && !cmd_port) rdata0 <= load_fmt;
            if (gnt1 && s_err)             rdata1 <= '0;
            else if (load_cap && cmd_port)  rdata1 <= load_fmt;
        end
    end

    assign p0.done  = done0;
    assign p1.done  = done1;
    assign p0.err   = err0;
    assign p1.err   = err1;
    assign p0.rdata = rdata0;
    assign p1.rdata = rdata1;

    assign mem_we   = ((state == S_ACCESS) & word_store) | (state == S_WRBACK);
    assign mem_addr = cmd_addr[MEM_AW+1:2];
    assign mem_din  = wr_word;
    assign busy     = ~idle;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//   Directed scenarios from the block's test plan plus a randomized mix of
//   loads/stores checked against a word-array reference memory.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int AW = 14;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_access_ctrl_if p0 ();
    dmem_access_ctrl_if p1 ();

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;
    logic          busy;

    dmem_access_ctrl #(.MEM_AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0       (p0),
        .p1       (p1),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    // Synchronous-read RAM behind the controller.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    bit [31:0] ref_mem [DEPTH];

    function automatic int widx(bit [31:0] a);
        return int'((a >> 2) & (DEPTH - 1));
    endfunction

    function automatic bit exp_err(bit we, bit [2:0] t, bit [31:0] a);
        if (we) return !(t == 0 || (t == 1 && a % 2 == 0) || (t == 2 && a % 4 == 0));
        case (t)
            0, 4:    return 1'b0;
            1, 5:    return a % 2 != 0;
            2:       return a % 4 != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit [31:0] exp_load(bit [2:0] t, bit [31:0] a);
        bit [31:0] w = ref_mem[widx(a)];
        int        off = int'(a % 4);
        bit [31:0] b = (w >> (8 * off)) & 32'hFF;
        bit [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (t)
            0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            4:       return b;
            1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            5:       return h;
            default: return w;
        endcase
    endfunction

    function automatic bit [31:0] exp_store(bit [2:0] t, bit [31:0] a, bit [31:0] d);
        bit [31:0] w = ref_mem[widx(a)];
        int        off = int'(a % 4);
        bit [31:0] mask;
        if (t == 2) return d;
        if (t == 0) begin
            mask = 32'hFF << (8 * off);
            return (w & ~mask) | ((d & 32'hFF) << (8 * off));
        end
        mask = 32'hFFFF << (16 * (off / 2));
        return (w & ~mask) | ((d & 32'hFFFF) << (16 * (off / 2)));
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(int port, bit req, bit we, bit [2:0] t, bit [31:0] a, bit [31:0] d);
        if (port == 1) begin
            p1.req = req; p1.we = we; p1.op_type = t; p1.addr = a; p1.wdata = d;
        end else begin
            p0.req = req; p0.we = we; p0.op_type = t; p0.addr = a; p0.wdata = d;
        end
    endtask

    // Issues one operation and records what happened until its done (or a
    // 12-cycle budget). lat = cycles from grant to done, -1 on timeout.
    task automatic do_op(input int port, input bit we, input bit [2:0] t,
                         input bit [31:0] a, input bit [31:0] d,
                         output bit [31:0] rdata, output bit err, output int lat,
                         output int nwr, output bit [31:0] wr_addr,
                         output bit [31:0] wr_data, output int wr_cyc);
        bit g;
        bit dn;
        rdata = '0; err = 1'b0; lat = -1; nwr = 0; wr_addr = '0; wr_data = '0; wr_cyc = -1;
        @(negedge clk);
        drive(port, 1'b1, we, t, a, d);
        g = 1'b0;
        for (int w = 0; w < 20 && !g; w++) begin
            #1;
            g = (port == 1) ? p1.gnt : p0.gnt;
            if (!g) @(negedge clk);
        end
        vectors++;
        if (g !== 1'b1) begin
            miscompares++;
            $display("FAIL grant_timeout port%0d: gnt=%b required 1", port, g);
            drive(port, 1'b0, we, t, a, d);
            return;
        end
        @(posedge clk);
        #1 drive(port, 1'b0, we, t, a, d);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_we) begin
                nwr++; wr_addr = 32'(mem_addr); wr_data = mem_din; wr_cyc = k;
            end
            dn = (port == 1) ? p1.done : p0.done;
            if (dn) begin
                lat   = k;
                rdata = (port == 1) ? p1.rdata : p0.rdata;
                err   = (port == 1) ? p1.err : p0.err;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    bit [31:0] rd, wa, wd;
    bit        er;
    int        lat, nwr, wc;

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        #12;
        vectors++; if (busy !== 1'b0 || mem_we !== 1'b0) begin miscompares++;
            $display("FAIL reset_busy_we: busy=%b mem_we=%b required 0/0", busy, mem_we); end
        vectors++; if ({p0.done, p1.done, p0.err, p1.err} !== 4'b0) begin miscompares++;
            $display("FAIL reset_done_err: %b required 0000", {p0.done, p1.done, p0.err, p1.err}); end
        vectors++; if (p0.rdata !== 32'h0 || p1.rdata !== 32'h0) begin miscompares++;
            $display("FAIL reset_rdata: p0=%h p1=%h required 0", p0.rdata, p1.rdata); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        drive(0, 1, 0, 2, 32'h0, 0);
        drive(1, 1, 0, 2, 32'h4, 0);
        #1;
        vectors++; if ({p0.gnt, p1.gnt} !== 2'b10) begin miscompares++;
            $display("FAIL reset_first_tie: gnt{p0,p1}=%b required 10", {p0.gnt, p1.gnt}); end
        drive(0, 0, 0, 2, 0, 0);
        drive(1, 0, 0, 2, 0, 0);
    endtask

    task automatic test_word();
        do_op(0, 1, 2, 32'h40, 32'hDEAD_BEEF, rd, er, lat, nwr, wa, wd, wc);
        ref_mem[widx(32'h40)] = 32'hDEAD_BEEF;
        vectors++; if (lat !== 2 || er !== 1'b0) begin miscompares++;
            $display("FAIL sw_latency: lat=%0d err=%b required 2/0", lat, er); end
        vectors++; if (nwr !== 1 || wc !== 1 || wa !== 32'h010 || wd !== 32'hDEAD_BEEF) begin miscompares++;
            $display("FAIL sw_write: n=%0d cyc=%0d addr=%h data=%h required 1/1/010/deadbeef", nwr, wc, wa, wd); end
        do_op(0, 0, 2, 32'h40, 0, rd, er, lat, nwr, wa, wd, wc);
        vectors++; if (lat !== 3 || rd !== 32'hDEAD_BEEF || nwr !== 0) begin miscompares++;
            $display("FAIL lw_read: lat=%0d rdata=%h writes=%0d required 3/deadbeef/0", lat, rd, nwr); end
    endtask

    task automatic test_subword_format();
        bit [2:0]  ty [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        bit [31:0] ad [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        bit [31:0] ex [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_F27F};
        do_op(1, 1, 2, 32'h100, 32'h8081_F27F, rd, er, lat, nwr, wa, wd, wc);
        ref_mem[widx(32'h100)] = 32'h8081_F27F;
        for (int i = 0; i < 4; i++) begin
            do_op(i % 2, 0, ty[i], ad[i], 0, rd, er, lat, nwr, wa, wd, wc);
            vectors++; if (rd !== ex[i] || lat !== 3 || er !== 1'b0) begin miscompares++;
                $display("FAIL fmt_%0d type=%b addr=%h: rdata=%h lat=%0d required %h/3", i, ty[i], ad[i], rd, lat, ex[i]); end
        end
    endtask

    task automatic test_rmw();
        do_op(0, 1, 2, 32'h100, 32'h1122_3344, rd, er, lat, nwr, wa, wd, wc);
        ref_mem[widx(32'h100)] = 32'h1122_3344;
        do_op(0, 1, 0, 32'h101, 32'h5A5A_5AAA, rd, er, lat, nwr, wa, wd, wc);
        vectors++; if (nwr !== 1 || wc !== 3 || wd !== 32'h1122_AA44 || wa !== 32'h040) begin miscompares++;
            $display("FAIL sb_rmw_write: n=%0d cyc=%0d addr=%h data=%h required 1/3/040/1122aa44", nwr, wc, wa, wd); end
        vectors++; if (lat !== 4 || er !== 1'b0) begin miscompares++;
            $display("FAIL sb_latency: lat=%0d err=%b required 4/0", lat, er); end
        ref_mem[widx(32'h100)] = 32'h1122_AA44;
        do_op(1, 1, 1, 32'h102, 32'h7777_BEEF, rd, er, lat, nwr, wa, wd, wc);
        vectors++; if (nwr !== 1 || wc !== 3 || wd !== 32'hBEEF_AA44 || lat !== 4) begin miscompares++;
            $display("FAIL sh_rmw_write: n=%0d cyc=%0d data=%h lat=%0d required 1/3/beefaa44/4", nwr, wc, wd, lat); end
        ref_mem[widx(32'h100)] = 32'hBEEF_AA44;
        do_op(0, 0, 2, 32'h100, 0, rd, er, lat, nwr, wa, wd, wc);
        vectors++; if (rd !== 32'hBEEF_AA44) begin miscompares++;
            $display("FAIL rmw_readback: rdata=%h required beefaa44", rd); end
    endtask

    task automatic test_errors();
        bit        we_t [3] = '{1'b0, 1'b1, 1'b0};
        bit [2:0]  ty   [3] = '{3'b010, 3'b001, 3'b111};
        bit [31:0] ad   [3] = '{32'h42, 32'h41, 32'h40};
        for (int i = 0; i < 3; i++) begin
            do_op(i % 2, we_t[i], ty[i], ad[i], 32'hFFFF_FFFF, rd, er, lat, nwr, wa, wd, wc);
            vectors++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nwr !== 0) begin miscompares++;
                $display("FAIL err_%0d: lat=%0d err=%b rdata=%h writes=%0d required 1/1/0/0", i, lat, er, rd, nwr); end
        end
        do_op(0, 0, 2, 32'h40, 0, rd, er, lat, nwr, wa, wd, wc);
        vectors++; if (rd !== ref_mem[widx(32'h40)]) begin miscompares++;
            $display("FAIL err_mem_untouched: rdata=%h required %h", rd, ref_mem[widx(32'h40)]); end
    endtask

    task automatic test_back_to_back();
        bit        pend [2];
        bit [31:0] exp_rd [2];
        int        gcyc [2];
        int        ngrant = 0, ndone = 0, last_g = -3;
        bit        g0, g1, dn;
        int        p;
        // Preload through port 1 so the pointer favours port 0 on the first tie.
        for (int i = 0; i < 6; i++) begin
            bit [31:0] v = $urandom;
            do_op(1, 1, 2, 32'h300 + 32'(4 * i), v, rd, er, lat, nwr, wa, wd, wc);
            ref_mem[widx(32'h300 + 32'(4 * i))] = v;
        end
        pend = '{1'b0, 1'b0};
        for (int cyc = 0; cyc < 80 && ndone < 6; cyc++) begin
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
                dn = (q == 1) ? p1.done : p0.done;
                if (dn) begin
                    rd = (q == 1) ? p1.rdata : p0.rdata;
                    vectors++; if (!pend[q] || rd !== exp_rd[q] || cyc - gcyc[q] !== 3) begin miscompares++;
                        $display("FAIL b2b_done port%0d: pending=%b rdata=%h lat=%0d required 1/%h/3", q, pend[q], rd, cyc - gcyc[q], exp_rd[q]); end
                    pend[q] = 1'b0;
                    ndone++;
                end
            end
            for (int q = 0; q < 2; q++)
                drive(q, !pend[q] && ngrant < 6, 0, 2, 32'h300 + 32'(4 * ngrant), 0);
            #1;
            g0 = p0.gnt; g1 = p1.gnt;
            if (busy && (g0 || g1)) begin
                vectors++; miscompares++;
                $display("FAIL b2b_gnt_while_busy: gnt{p0,p1}=%b required 00", {g0, g1});
            end
            if (g0 || g1) begin
                p = g1 ? 1 : 0;
                vectors++; if ({g0, g1} === 2'b11 || p !== ngrant % 2 || (ngrant > 0 && cyc - last_g !== 3)) begin miscompares++;
                    $display("FAIL b2b_grant_%0d: gnt{p0,p1}=%b gap=%0d required port%0d gap 3", ngrant, {g0, g1}, cyc - last_g, ngrant % 2); end
                pend[p]   = 1'b1;
                gcyc[p]   = cyc;
                exp_rd[p] = ref_mem[widx(32'h300 + 32'(4 * ngrant))];
                last_g    = cyc;
                ngrant++;
            end
        end
        drive(0, 0, 0, 2, 0, 0);
        drive(1, 0, 0, 2, 0, 0);
        vectors++; if (ngrant !== 6 || ndone !== 6) begin miscompares++;
            $display("FAIL b2b_count: grants=%0d dones=%0d required 6/6", ngrant, ndone); end
    endtask

    task automatic test_random();
        bit [2:0] tys [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b111};
        for (int i = 0; i < 40; i++) begin
            int        port = int'($urandom_range(1, 0));
            bit        we   = 1'($urandom_range(1, 0));
            bit [2:0]  t    = tys[$urandom_range(7, 0)];
            bit [31:0] a    = 32'h200 + $urandom_range(63, 0);
            bit [31:0] d    = $urandom;
            bit        e    = exp_err(we, t, a);
            int        el   = e ? 1 : (!we ? 3 : (t == 2 ? 2 : 4));
            bit [31:0] ew   = (!e && we) ? exp_store(t, a, d) : 32'h0;
            bit [31:0] er_d = (!e && !we) ? exp_load(t, a) : 32'h0;
            do_op(port, we, t, a, d, rd, er, lat, nwr, wa, wd, wc);
            vectors++; if (lat !== el || er !== e) begin miscompares++;
                $display("FAIL rand_%0d we=%b t=%b a=%h: lat=%0d err=%b required %0d/%b", i, we, t, a, lat, er, el, e); end
            if (!e && !we) begin
                vectors++; if (rd !== er_d || nwr !== 0) begin miscompares++;
                    $display("FAIL rand_%0d load t=%b a=%h: rdata=%h writes=%0d required %h/0", i, t, a, rd, nwr, er_d); end
            end else if (!e) begin
                vectors++; if (nwr !== 1 || wd !== ew || wa !== 32'(widx(a))) begin miscompares++;
                    $display("FAIL rand_%0d store t=%b a=%h: n=%0d data=%h addr=%h required 1/%h/%h", i, t, a, nwr, wd, wa, ew, widx(a)); end
                ref_mem[widx(a)] = ew;
            end else begin
                vectors++; if (nwr !== 0 || rd !== 32'h0) begin miscompares++;
                    $display("FAIL rand_%0d error: writes=%0d rdata=%h required 0/0", i, nwr, rd); end
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int bad = 0;
        do_op(0, 1, 2, 32'h400, 32'h5566_7788, rd, er, lat, nwr, wa, wd, wc);
        ref_mem[widx(32'h400)] = 32'h5566_7788;
        @(negedge clk);
        drive(0, 1, 1, 0, 32'h401, 32'h99);
        @(posedge clk);
        #1 drive(0, 0, 1, 0, 32'h401, 32'h99);
        @(negedge clk);              // ACCESS
        @(negedge clk);              // CAPTURE
        rst_n = 1'b0;
        #1;
        vectors++; if (mem_we !== 1'b0 || busy !== 1'b0 || p0.done !== 1'b0) begin miscompares++;
            $display("FAIL rst_rmw_immediate: mem_we=%b busy=%b done=%b required 0/0/0", mem_we, busy, p0.done); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (mem_we || p0.done || p1.done) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++;
            $display("FAIL rst_rmw_quiet: %0d cycles with mem_we/done, required 0", bad); end
        do_op(1, 0, 2, 32'h400, 0, rd, er, lat, nwr, wa, wd, wc);
        vectors++; if (rd !== 32'h5566_7788 || lat !== 3) begin miscompares++;
            $display("FAIL rst_rmw_mem: rdata=%h lat=%0d required 55667788/3", rd, lat); end
        @(negedge clk);
        drive(0, 1, 0, 2, 32'h400, 0);
        drive(1, 1, 0, 2, 32'h400, 0);
        #1;
        vectors++; if ({p0.gnt, p1.gnt} !== 2'b10) begin miscompares++;
            $display("FAIL rst_tie_after_p1: gnt{p0,p1}=%b required 10", {p0.gnt, p1.gnt}); end
        drive(0, 0, 0, 2, 0, 0);
        drive(1, 0, 0, 2, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_back_to_back();
        test_word();
        test_subword_format();
        test_rmw();
        test_errors();
        test_random();
        test_reset_mid_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
